highlight_blend: RTL and testbench

- Parametrised successor to the motion-detect highlight stage.
- Merges a per-pixel motion mask FIFO with the original-image FIFO and writes a marked image to the output FIFO.
- Fully pipelined: sustains 1 pixel/cycle, where the previous stage needed 2.
- Adds a runtime-selectable threshold and mark mode (pass, replace, 50% blend).
- Sits between the mask-generation stage and the image writer.

---
 rtl/highlight_pkg.sv | 26 ++
 rtl/highlight_pix_op.sv | 43 ++++
 rtl/highlight_blend.sv | 107 ++++++++++
 tb/tb_highlight_blend.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/highlight_pkg.sv
// Shared types and defaults for the highlight blend stage.
package highlight_pkg;

  localparam int              CHAN_W_DEF   = 8;
  localparam int              NUM_CHAN_DEF = 3;
  localparam logic [23:0]     HL_COLOR_DEF = 24'h0000FF;

  // Encodings 0..2 are named; 3 behaves as pass.
  typedef enum logic [1:0] {
    HL_PASS    = 2'd0,
    HL_REPLACE = 2'd1,
    HL_BLEND   = 2'd2
  } hl_mode_e;

  // 50% blend of one default-width channel; the carry is kept so the
  // halved sum never wraps.
  function automatic logic [CHAN_W_DEF-1:0] blend_chan(
    input logic [CHAN_W_DEF-1:0] a,
    input logic [CHAN_W_DEF-1:0] b
  );
    logic [CHAN_W_DEF:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[CHAN_W_DEF:1];
  endfunction

endpackage

// File: rtl/highlight_pix_op.sv
// Combinational per-pixel mark function: pass, replace or 50% blend.
module highlight_pix_op
  import highlight_pkg::*;
#(
  parameter int                          CHAN_W   = CHAN_W_DEF,
  parameter int                          NUM_CHAN = NUM_CHAN_DEF,
  localparam int                         PIX_W    = CHAN_W * NUM_CHAN,
  parameter logic [CHAN_W*NUM_CHAN-1:0]  HL_COLOR = HL_COLOR_DEF
) (
  input  logic [1:0]       mode,
  input  logic             hit,
  input  logic [PIX_W-1:0] orig,
  output logic [PIX_W-1:0] pix
);

  logic [PIX_W-1:0] blended;

  for (genvar c = 0; c < NUM_CHAN; c++) begin : g_chan
    logic [CHAN_W-1:0] o_c;
    logic [CHAN_W-1:0] h_c;
    assign o_c = orig[c*CHAN_W +: CHAN_W];
    assign h_c = HL_COLOR[c*CHAN_W +: CHAN_W];
    // Package helper covers the default channel width; other widths inline the same math.
    if (CHAN_W == CHAN_W_DEF) begin : g_pkg
      assign blended[c*CHAN_W +: CHAN_W] = blend_chan(o_c, h_c);
    end else begin : g_gen
      logic [CHAN_W:0] sum;
      assign sum = {1'b0, o_c} + {1'b0, h_c};
      assign blended[c*CHAN_W +: CHAN_W] = sum[CHAN_W:1];
    end
  end

  // Select the marked pixel for the current mode.
  always_comb begin
    pix = orig;
    case (hl_mode_e'(mode))
      HL_REPLACE: if (hit) pix = HL_COLOR;
      HL_BLEND:   if (hit) pix = blended;
      default:    pix = orig;
    endcase
  end

endmodule

// File: rtl/highlight_blend.sv
// Merges the motion-mask and original-image FIFOs into a marked output
// stream at one pixel per cycle. Optional per-frame hit statistics are
// built when HIGHLIGHT_STATS_EN is defined.
module highlight_blend
  import highlight_pkg::*;
#(
  parameter int                          CHAN_W       = CHAN_W_DEF,
  parameter int                          NUM_CHAN     = NUM_CHAN_DEF,
  parameter int                          MASK_W       = 8,
  localparam int                         PIX_W        = CHAN_W * NUM_CHAN,
  parameter logic [CHAN_W*NUM_CHAN-1:0]  HL_COLOR     = HL_COLOR_DEF,
  parameter int                          FRAME_PIXELS = 720 * 540
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        mode,
  input  logic [MASK_W-1:0] mask_thresh,
  output logic              mask_rd_en,
  input  logic              mask_empty,
  input  logic [MASK_W-1:0] mask_dout,
  output logic              original_rd_en,
  input  logic              original_empty,
  input  logic [PIX_W-1:0]  original_dout,
  output logic              img_out_wr_en,
  input  logic              img_out_full,
  output logic [PIX_W-1:0]  img_out_din,
  output logic [31:0]       hl_count,
  output logic              hl_count_valid
);

  logic             out_valid;
  logic [PIX_W-1:0] out_pix;
  logic [PIX_W-1:0] next_pix;
  logic             accept;
  logic             hit;

  // Reset gates pops and pushes so a held pixel is dropped, never written.
  assign accept         = !reset && !mask_empty && !original_empty
                          && (!out_valid || !img_out_full);
  assign mask_rd_en     = accept;
  assign original_rd_en = accept;
  assign img_out_wr_en  = !reset && out_valid && !img_out_full;
  assign img_out_din    = out_valid ? out_pix : '0;
  assign hit            = (mask_dout >= mask_thresh);

  highlight_pix_op #(
    .CHAN_W   (CHAN_W),
    .NUM_CHAN (NUM_CHAN),
    .HL_COLOR (HL_COLOR)
  ) u_pix_op (
    .mode (mode),
    .hit  (hit),
    .orig (original_dout),
    .pix  (next_pix)
  );

  // Output holding register: load on accept, empty once written.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_pix   <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_pix   <= next_pix;
    end else if (img_out_wr_en) begin
      out_valid <= 1'b0;
    end
  end

`ifdef HIGHLIGHT_STATS_EN
  localparam logic [31:0] LAST_PIX = 32'(FRAME_PIXELS - 1);

  logic [31:0] pix_cnt;
  logic [31:0] hit_cnt;
  logic        hit_contrib;

  assign hit_contrib = hit && ((hl_mode_e'(mode) == HL_REPLACE) ||
                               (hl_mode_e'(mode) == HL_BLEND));

  // Per-frame hit counting; publish the total on the frame's last accept.
  always_ff @(posedge clock) begin
    if (reset) begin
      pix_cnt        <= '0;
      hit_cnt        <= '0;
      hl_count       <= '0;
      hl_count_valid <= 1'b0;
    end else begin
      hl_count_valid <= 1'b0;
      if (accept) begin
        if (pix_cnt == LAST_PIX) begin
          pix_cnt        <= '0;
          hit_cnt        <= '0;
          hl_count       <= hit_cnt + 32'(hit_contrib);
          hl_count_valid <= 1'b1;
        end else begin
          pix_cnt <= pix_cnt + 32'd1;
          hit_cnt <= hit_cnt + 32'(hit_contrib);
        end
      end
    end
  end
`else
  assign hl_count       = '0;
  assign hl_count_valid = 1'b0;
`endif

endmodule

// File: tb/tb_highlight_blend.sv
// Directed bench for highlight_blend; FIFOs are modelled as queues with
// show-ahead heads. Stats checks depend on HIGHLIGHT_STATS_EN.
module tb_highlight_blend;

  logic        clock;
  logic        reset;
  logic [1:0]  mode;
  logic [7:0]  mask_thresh;
  logic        mask_rd_en;
  logic        mask_empty;
  logic [7:0]  mask_dout;
  logic        original_rd_en;
  logic        original_empty;
  logic [23:0] original_dout;
  logic        img_out_wr_en;
  logic        img_out_full;
  logic [23:0] img_out_din;
  logic [31:0] hl_count;
  logic        hl_count_valid;

  highlight_blend #(
    .CHAN_W       (8),
    .NUM_CHAN     (3),
    .MASK_W       (8),
    .HL_COLOR     (24'h0000FF),
    .FRAME_PIXELS (16)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .mode           (mode),
    .mask_thresh    (mask_thresh),
    .mask_rd_en     (mask_rd_en),
    .mask_empty     (mask_empty),
    .mask_dout      (mask_dout),
    .original_rd_en (original_rd_en),
    .original_empty (original_empty),
    .original_dout  (original_dout),
    .img_out_wr_en  (img_out_wr_en),
    .img_out_full   (img_out_full),
    .img_out_din    (img_out_din),
    .hl_count       (hl_count),
    .hl_count_valid (hl_count_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [7:0]  mq[$];
  logic [23:0] oq[$];
  logic [23:0] wq[$];

  int checks = 0;
  int errors = 0;

  logic        s_wr, s_rd, s_ord;
  logic [23:0] s_din;
  int          pulses;
  logic [31:0] last_hl;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_fifos();
    mask_empty     = (mq.size() == 0);
    mask_dout      = mask_empty ? 8'h00 : mq[0];
    original_empty = (oq.size() == 0);
    original_dout  = original_empty ? 24'h0 : oq[0];
  endtask

  // Sample at negedge, apply the FIFO side effects just after the posedge.
  task automatic tick();
    @(negedge clock);
    s_wr  = img_out_wr_en;
    s_rd  = mask_rd_en;
    s_ord = original_rd_en;
    s_din = img_out_din;
    if (hl_count_valid) begin
      pulses++;
      last_hl = hl_count;
    end
    @(posedge clock);
    #1;
    if (s_rd && mq.size() > 0) void'(mq.pop_front());
    if (s_ord && oq.size() > 0) void'(oq.pop_front());
    if (s_wr) wq.push_back(s_din);
    drive_fifos();
  endtask

  task automatic push(input logic [7:0] m, input logic [23:0] o);
    mq.push_back(m);
    oq.push_back(o);
    drive_fifos();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check("rd_pair", {31'd0, s_rd}, {31'd0, s_ord});
    end
  endtask

  task automatic expect_out(input string tag, input logic [23:0] exp);
    logic [23:0] got;
    got = (wq.size() > 0) ? wq.pop_front() : 24'hxxxxxx;
    check(tag, {8'h0, got}, {8'h0, exp});
  endtask

  initial begin
    reset        = 1'b1;
    mode         = 2'd0;
    mask_thresh  = 8'h00;
    img_out_full = 1'b0;
    pulses       = 0;
    last_hl      = '0;
    drive_fifos();
    tick();
    tick();
    check("rst_wr",    {31'd0, img_out_wr_en},  32'd0);
    check("rst_din",   {8'd0, img_out_din},     32'd0);
    check("rst_rd",    {31'd0, mask_rd_en},     32'd0);
    check("rst_hl",    hl_count,                32'd0);
    check("rst_hlv",   {31'd0, hl_count_valid}, 32'd0);
    reset = 1'b0;

    // Streaming replace, one write per cycle.
    mode = 2'd1; mask_thresh = 8'h80;
    push(8'hFF, 24'h123456);
    push(8'h7F, 24'hABCDEF);
    push(8'h80, 24'h111111);
    push(8'h00, 24'h222222);
    tick();
    check("lat_wr0", {31'd0, s_wr}, 32'd0);
    check("lat_rd0", {31'd0, s_rd}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stream_wr", {31'd0, s_wr}, 32'd1);
    end
    expect_out("rep_ff",  24'h0000FF);
    expect_out("rep_7f",  24'hABCDEF);
    expect_out("rep_80",  24'h0000FF);
    expect_out("rep_00",  24'h222222);
    check("stream_cnt", wq.size(), 32'd0);

    // Blend with carry into the halved sum.
    mode = 2'd2;
    push(8'hFF, 24'h204060);
    push(8'h10, 24'h204060);
    push(8'hFF, 24'hFFFFFF);
    push(8'h80, 24'h000000);
    run(6);
    expect_out("blend_a", 24'h1020AF);
    expect_out("blend_m", 24'h204060);
    expect_out("blend_f", 24'h7F7FFF);
    expect_out("blend_z", 24'h00007F);

    mode = 2'd3;
    push(8'hFF, 24'h204060);
    run(3);
    expect_out("mode3", 24'h204060);
    mode = 2'd0;
    push(8'hFF, 24'h123456);
    run(3);
    expect_out("mode0", 24'h123456);

    // Backpressure: held pixel stable, no pops, mode change ignored.
    mode = 2'd1;
    push(8'hFF, 24'h010203);
    push(8'h00, 24'h040506);
    push(8'h00, 24'h070809);
    tick();
    check("bp_rd0", {31'd0, s_rd}, 32'd1);
    img_out_full = 1'b1;
    mode = 2'd0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_rd",  {31'd0, s_rd}, 32'd0);
      check("bp_wr",  {31'd0, s_wr}, 32'd0);
      check("bp_din", {8'd0, s_din}, 32'h0000FF);
    end
    img_out_full = 1'b0;
    tick();
    check("bp_rel_wr", {31'd0, s_wr}, 32'd1);
    check("bp_rel_rd", {31'd0, s_rd}, 32'd1);
    run(3);
    expect_out("bp_0", 24'h0000FF);
    expect_out("bp_1", 24'h040506);
    expect_out("bp_2", 24'h070809);

    // Starvation: only the mask FIFO has data.
    mode = 2'd1;
    mq.push_back(8'h80);
    drive_fifos();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("starve_rd",  {31'd0, s_rd},  32'd0);
      check("starve_ord", {31'd0, s_ord}, 32'd0);
      check("starve_wr",  {31'd0, s_wr},  32'd0);
    end
    oq.push_back(24'hABCDEF);
    drive_fifos();
    tick();
    check("feed_rd",  {31'd0, s_rd},  32'd1);
    check("feed_ord", {31'd0, s_ord}, 32'd1);
    tick();
    check("feed_wr", {31'd0, s_wr}, 32'd1);
    expect_out("feed_pix", 24'h0000FF);

    // Reset while a pixel is held.
    push(8'h00, 24'h5A5A5A);
    tick();
    reset = 1'b1;
    tick();
    check("mrst_wr_in", {31'd0, s_wr}, 32'd0);
    reset = 1'b0;
    check("mrst_wr",  {31'd0, img_out_wr_en}, 32'd0);
    check("mrst_din", {8'd0, img_out_din},    32'd0);
    run(2);
    check("mrst_drop", wq.size(), 32'd0);

`ifdef HIGHLIGHT_STATS_EN
    mode = 2'd1;
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      push((i == 0 || i == 3 || i == 7 || i == 11 || i == 15) ? 8'hFF : 8'h00,
           24'(i));
    end
    run(19);
    check("st1_pulses", pulses, 32'd1);
    check("st1_count",  last_hl, 32'd5);
    wq.delete();
    mode = 2'd0;
    pulses = 0;
    for (int i = 0; i < 16; i++) push(8'hFF, 24'(i));
    run(19);
    check("st2_pulses", pulses, 32'd1);
    check("st2_count",  last_hl, 32'd0);
    check("st2_out",    wq.size(), 32'd16);
`else
    check("nost_count",  hl_count, 32'd0);
    check("nost_pulses", pulses,   32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
